// File: rtl/inert_pkg.sv
// Shared types and saturation helpers for the inertial integrator.
// Rate samples are RATE_W-bit signed; integrators use a caller-chosen width.
package inert_pkg;

  typedef enum logic [1:0] {IDLE, CAL, RUN} state_e;

  localparam int RATE_W = 16;

  function automatic logic signed [RATE_W-1:0] sat16(input logic signed [RATE_W:0] v);
    if (v > 17'sd32767)       return 16'sh7FFF;
    else if (v < -17'sd32768) return 16'sh8000;
    else                      return v[RATE_W-1:0];
  endfunction

  // Clamp v to the signed range of a w-bit integer (w <= 31).
  function automatic logic signed [31:0] sat_int(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = 32'sh7FFF_FFFF >>> (32 - w);
    lo = ~hi;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/inert_if.sv
// Sample/angle bus between inert_intf, the integrator and flight control.
interface inert_if;
  import inert_pkg::*;

  logic                     strt_cal;
  logic                     vld;
  logic signed [RATE_W-1:0] ptch_rt;
  logic signed [RATE_W-1:0] roll_rt;
  logic signed [RATE_W-1:0] yaw_rt;
  logic signed [RATE_W-1:0] ax;
  logic signed [RATE_W-1:0] ay;
  logic                     cal_done;
  logic                     ang_vld;
  logic signed [RATE_W-1:0] ptch;
  logic signed [RATE_W-1:0] roll;
  logic signed [RATE_W-1:0] yaw;

  modport master (
    output strt_cal, vld, ptch_rt, roll_rt, yaw_rt, ax, ay,
    input  cal_done, ang_vld, ptch, roll, yaw
  );

  modport slave (
    input  strt_cal, vld, ptch_rt, roll_rt, yaw_rt, ax, ay,
    output cal_done, ang_vld, ptch, roll, yaw
  );
endinterface

// File: rtl/inert_axis.sv
// One gyro axis: offset averaging, offset-compensated rate, saturating
// integrator with optional accel fusion nudge. Angle = top 16 integrator bits.
module inert_axis
  import inert_pkg::*;
#(
  parameter int INT_W     = 27,
  parameter int FUSION    = 512,
  parameter bit FUSE_EN   = 1'b1,
  parameter int CAL_SHIFT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr,
  input  logic                     i_cal_smp,
  input  logic                     i_cal_last,
  input  logic                     i_run_smp,
  input  logic signed [RATE_W-1:0] i_rt,
  input  logic signed [RATE_W-1:0] i_acc_ang,
  output logic signed [RATE_W-1:0] o_ang
);
  localparam int ACC_W = RATE_W + CAL_SHIFT;

  logic signed [ACC_W-1:0]  r_acc;
  logic signed [ACC_W-1:0]  w_acc_sum;
  logic signed [RATE_W-1:0] r_off;
  logic signed [RATE_W-1:0] w_comp;
  logic signed [INT_W-1:0]  r_int;
  logic signed [INT_W-1:0]  w_int_next;
  logic signed [31:0]       w_fuse;
  logic signed [31:0]       w_int_sum;

  assign w_acc_sum = r_acc + ACC_W'(i_rt);
  assign w_comp    = sat16(17'(i_rt) - 17'(r_off));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_fuse = '0;
    if (FUSE_EN) begin
      if (i_acc_ang > o_ang)      w_fuse = FUSION;
      else if (i_acc_ang < o_ang) w_fuse = -FUSION;
    end
  end

  assign w_int_sum  = 32'(r_int) + 32'(w_comp) + w_fuse;
  assign w_int_next = INT_W'(sat_int(w_int_sum, INT_W));
  assign o_ang      = r_int[INT_W-1 -: RATE_W];

  // NOTE: state uses non-blocking assignments; reset is synchronous, so it lives inside the edge branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_off <= '0;
      r_int <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
      r_int <= '0;
    end else if (i_cal_smp) begin
      r_acc <= w_acc_sum;
      if (i_cal_last) r_off <= RATE_W'(w_acc_sum >>> CAL_SHIFT);
    end else if (i_run_smp) begin
      r_int <= w_int_next;
    end
  end
endmodule

// File: rtl/inertial_integrator.sv
// Calibrates gyro offsets, integrates rates into pitch/roll/yaw and fuses
// accel-derived pitch/roll to cancel drift.
module inertial_integrator
  import inert_pkg::*;
#(
  parameter int CAL_SHIFT = 3,
  parameter int INT_W     = 27,
  parameter int FUSION    = 512,
  parameter int ACC_SCALE = 469
) (
  input logic  clk,
  input logic  rst,
  inert_if.slave bus
);
  localparam logic signed [11:0] ACC_S = 12'(ACC_SCALE);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [CAL_SHIFT-1:0]  r_cnt;
  logic                  r_cal_done;
  logic                  r_ang_vld;
  logic                  w_cal_smp;
  logic                  w_cal_last;
  logic                  w_run_smp;
  logic signed [27:0]    w_ptch_prod;
  logic signed [27:0]    w_roll_prod;
  logic signed [RATE_W-1:0] w_ptch_acc;
  logic signed [RATE_W-1:0] w_roll_acc;

  // strt_cal overrides any coincident sample.
  assign w_cal_smp  = (r_state == CAL) && bus.vld && !bus.strt_cal;
  assign w_cal_last = w_cal_smp && (r_cnt == '1);
  assign w_run_smp  = (r_state == RUN) && bus.vld && !bus.strt_cal;

  always_comb begin
    w_state_nxt = r_state;
    if (bus.strt_cal) begin
      w_state_nxt = CAL;
    end else begin
      case (r_state)
        CAL:     if (w_cal_last) w_state_nxt = RUN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_cal_done <= 1'b0;
      r_ang_vld  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cal_done <= w_cal_last;
      r_ang_vld  <= w_run_smp;
      if (bus.strt_cal)   r_cnt <= '0;
      else if (w_cal_smp) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_ptch_prod = 28'(bus.ay) * 28'(ACC_S);
  assign w_roll_prod = 28'(bus.ax) * 28'(ACC_S);
  assign w_ptch_acc  = RATE_W'(w_ptch_prod >>> 13);
  assign w_roll_acc  = RATE_W'(w_roll_prod >>> 13);

  inert_axis #(.INT_W(INT_W), .FUSION(FUSION), .FUSE_EN(1'b1), .CAL_SHIFT(CAL_SHIFT)) u_ptch (
    .clk(clk), .rst(rst), .i_clr(bus.strt_cal), .i_cal_smp(w_cal_smp), .i_cal_last(w_cal_last),
    .i_run_smp(w_run_smp), .i_rt(bus.ptch_rt), .i_acc_ang(w_ptch_acc), .o_ang(bus.ptch)
  );

  inert_axis #(.INT_W(INT_W), .FUSION(FUSION), .FUSE_EN(1'b1), .CAL_SHIFT(CAL_SHIFT)) u_roll (
    .clk(clk), .rst(rst), .i_clr(bus.strt_cal), .i_cal_smp(w_cal_smp), .i_cal_last(w_cal_last),
    .i_run_smp(w_run_smp), .i_rt(bus.roll_rt), .i_acc_ang(w_roll_acc), .o_ang(bus.roll)
  );

  inert_axis #(.INT_W(INT_W), .FUSION(FUSION), .FUSE_EN(1'b0), .CAL_SHIFT(CAL_SHIFT)) u_yaw (
    .clk(clk), .rst(rst), .i_clr(bus.strt_cal), .i_cal_smp(w_cal_smp), .i_cal_last(w_cal_last),
    .i_run_smp(w_run_smp), .i_rt(bus.yaw_rt), .i_acc_ang('0), .o_ang(bus.yaw)
  );

  assign bus.cal_done = r_cal_done;
  assign bus.ang_vld  = r_ang_vld;
endmodule
